keypad_key_fifo: RTL
====================

Name: keypad_key_fifo

Overview:
Downstream consumer of the keypad scanner. Debounces the scanner's decoded key code and a key-down qualifier, then emits one event per debounced press. Each event is pushed as a 4-bit key code into a small show-ahead FIFO. Firmware or an FSM drains the FIFO with a valid/read handshake, so no key press is lost between polls.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a press or a release; legal range 2 to 65535.
DEPTH, 8, FIFO entries; power of two, at least 2.
REPEAT_CYCLES, 4096, auto-repeat interval in cycles; used only with the optional feature.

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
key_in  input  4  decoded key code from the scanner, synchronous to clk
key_down  input  1  high while any column is low, i.e. NOT(AND of col); synchronous to clk
rd_en  input  1  pop request from the consumer
ovf_clr  input  1  clears the sticky overflow flag
rd_data  output  4  head-of-FIFO key code; valid only while rd_valid is high
rd_valid  output  1  FIFO not empty
count  output  $clog2(DEPTH+1)  current number of stored entries
overflow  output  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high) clears the FSM, debounce counter, FIFO pointers and overflow.
  - Reset values: FSM=IDLE, rd_valid=0, count=0, overflow=0, rd_data=0.
  - Reset mid-press discards the press in progress; a key still held after reset is re-debounced from IDLE.
- FSM states: IDLE, PRESS_DB, HELD, REL_DB. The debounce counter is 16 bits.
  - IDLE: on key_down=1, latch cand<=key_in, clear the counter, go to PRESS_DB.
  - PRESS_DB: while key_down=1 and key_in==cand, increment the counter.
    - When the counter reaches DEBOUNCE_CYCLES-1: push cand and go to HELD.
    - On key_down=0 or key_in!=cand: go to IDLE with no push.
  - HELD: key_in changes are ignored (one event per press). On key_down=0, clear the counter and go to REL_DB.
  - REL_DB: on key_down=1 (any code), return to HELD with no push. After DEBOUNCE_CYCLES consecutive key_down=0 cycles, go to IDLE.
- Latency:
  - Push occurs on the edge where the counter hits DEBOUNCE_CYCLES-1, i.e. the DEBOUNCE_CYCLES-th stable cycle, counting the IDLE->PRESS_DB cycle as 0.
  - rd_valid and rd_data update on the following edge.
- FIFO (show-ahead):
  - rd_data always shows the head entry.
  - rd_en with rd_valid=1 pops on that edge.
  - rd_en with rd_valid=0 is ignored; no underflow state.
- Push while full and no pop: the entry is dropped, overflow<=1, and count stays at DEPTH.
- Push and pop on the same edge:
  - Both are performed and count is unchanged, including when full (the push is accepted, no overflow).
  - When empty, only the push takes effect.
- ovf_clr clears overflow on the next edge. If a dropped push occurs on the same edge, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. count ranges from 0 to DEPTH.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: HELD runs a repeat counter that restarts on entry to HELD. Every REPEAT_CYCLES cycles in HELD, cand is pushed again. REL_DB->HELD restarts the repeat counter. Overflow rules apply to repeat pushes.
- Undefined: no repeat logic and REPEAT_CYCLES is unused; exactly one push per press.

Decomposition:
- Shared package keypad_pkg holds:
  - the key-code typedef (4-bit);
  - the FSM state enum {IDLE, PRESS_DB, HELD, REL_DB};
  - constants KEY_STAR=4'hE and KEY_HASH=4'hF.
- One sub-module is natural: keypad_sync_fifo, a parameterised show-ahead FIFO with width and depth parameters, providing push, pop, full, empty, count and a dropped indication.
- The debounce FSM stays in the top level.

Test Plan:
- DEBOUNCE_CYCLES=4: key_in=4'h5 with key_down=1 for 10 cycles, then released for 10 cycles -> exactly one entry; rd_valid rises 5 edges after key_down rose; rd_data=4'h5; count=1.
- Bounce: key_down toggles 1,1,0,1,1,0 with key_in=4'h3 -> no push. A later stable 4 cycles -> one push of 4'h3.
- Code change during PRESS_DB (4'h2 for 2 cycles, then 4'h8 stable) -> only 4'h8 pushed. Change during HELD -> nothing pushed.
- DEPTH=4: push 5 presses (1,2,3,4,6) without reads -> count=4, overflow=1, entries read out 1,2,3,4. ovf_clr -> overflow=0.
- Full FIFO, a push coincides with rd_en -> count stays 4, no overflow; the new code appears last in order.
- Assert rst during PRESS_DB with 2 entries stored -> count=0, rd_valid=0 immediately. With the key still held after release of rst, one push occurs after DEBOUNCE_CYCLES.
- With KEYPAD_AUTOREPEAT_EN, REPEAT_CYCLES=20, key 4'hA held 70 cycles -> 4 entries of 4'hA.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad key FIFO block.
package keypad_pkg;

  localparam int KEY_W = 4;

  typedef logic [KEY_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } kp_state_t;

  localparam key_code_t KEY_STAR = 4'hE;
  localparam key_code_t KEY_HASH = 4'hF;

endpackage

// File: rtl/keypad_key_fifo_if.sv
// Read-side bus of the keypad key FIFO: pop handshake, head data,
// fill level and the sticky overflow flag with its clear.
// The slave modport is the FIFO block, the master modport the consumer.
interface keypad_key_fifo_if
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic            rd_en;
  logic            ovf_clr;
  key_code_t       rd_data;
  logic            rd_valid;
  logic [CW-1:0]   count;
  logic            overflow;

  modport master (
    output rd_en,
    output ovf_clr,
    input  rd_data,
    input  rd_valid,
    input  count,
    input  overflow
  );

  modport slave (
    input  rd_en,
    input  ovf_clr,
    output rd_data,
    output rd_valid,
    output count,
    output overflow
  );

endinterface

// File: rtl/keypad_sync_fifo.sv
// Parameterised show-ahead FIFO. rdata always presents the head entry
// (zero while empty). A pop on an empty FIFO is ignored; a push while
// full is accepted only if a pop happens on the same edge, otherwise it
// is dropped and flagged on the combinational dropped output.
module keypad_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_pop;
  logic             do_push;

  // Decide which requests actually take effect this edge; a pop frees the
  // slot a simultaneous push into a full FIFO needs.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    dropped = push && full && !do_pop;
    rdata   = empty ? '0 : mem[rd_ptr];
    count   = cnt_q;
  end

  // Storage array; no reset needed because empty masks stale contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; the counter tracks the fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// Keypad key FIFO: debounces the scanner's key code and key-down
// qualifier, emits one event per debounced press into a show-ahead FIFO
// drained over a valid/read handshake, with a sticky overflow flag.
// Optional build macro KEYPAD_AUTOREPEAT_EN adds auto-repeat pushes
// every REPEAT_CYCLES cycles while a key stays held.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEPTH           = 8,
  parameter int REPEAT_CYCLES   = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  key_code_t            key_in,
  input  logic                 key_down,
  keypad_key_fifo_if.slave     bus
);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
      DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("keypad_key_fifo: illegal parameter value");
  end

  localparam int CW = $clog2(DEPTH + 1);

  // The press/release completes on the edge the counter reaches
  // DEBOUNCE_CYCLES-1, so the transition is taken when it holds one less.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 2);

  kp_state_t   state;
  kp_state_t   state_n;
  key_code_t   cand;
  key_code_t   cand_n;
  logic [15:0] db_cnt;
  logic [15:0] db_cnt_n;
  logic        push_q;
  logic        push_n;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_cnt_n;
`endif

  key_code_t     fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          fifo_dropped;
  logic          overflow_q;

  // Debounce FSM next-state logic; a push is requested one edge ahead of
  // the FIFO write so the event lands on the edge after debounce completes.
  always_comb begin
    state_n  = state;
    cand_n   = cand;
    db_cnt_n = db_cnt;
    push_n   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_cnt_n = rpt_cnt;
`endif
    case (state)
      IDLE: begin
        if (key_down) begin
          cand_n   = key_in;
          db_cnt_n = '0;
          state_n  = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (key_down && (key_in == cand)) begin
          db_cnt_n = db_cnt + 16'd1;
          if (db_cnt == DB_LAST) begin
            push_n  = 1'b1;
            state_n = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt_n = '0;
`endif
          end
        end else begin
          state_n = IDLE;
        end
      end
      HELD: begin
        if (!key_down) begin
          db_cnt_n = '0;
          state_n  = REL_DB;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rpt_cnt == RPT_LAST) begin
            push_n    = 1'b1;
            rpt_cnt_n = '0;
          end else begin
            rpt_cnt_n = rpt_cnt + 1'b1;
          end
`endif
        end
      end
      REL_DB: begin
        if (key_down) begin
          state_n = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_cnt_n = '0;
`endif
        end else if (db_cnt == DB_LAST) begin
          state_n = IDLE;
        end else begin
          db_cnt_n = db_cnt + 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Debounce FSM registers; reset abandons any press in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cand   <= '0;
      db_cnt <= '0;
      push_q <= 1'b0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      db_cnt <= db_cnt_n;
      push_q <= push_n;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // Auto-repeat interval counter, restarted whenever HELD is entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt_n;
    end
  end
`endif

  // cand is stable through HELD, so it is still the pressed code when the
  // delayed push reaches the FIFO.
  keypad_sync_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_q),
    .wdata   (cand),
    .pop     (bus.rd_en),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .dropped (fifo_dropped)
  );

  // Sticky overflow: a dropped push (only possible while full) sets it and
  // wins over a clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (fifo_dropped && fifo_full) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  // Drive the consumer-facing bus.
  always_comb begin
    bus.rd_data  = fifo_rdata;
    bus.rd_valid = !fifo_empty;
    bus.count    = fifo_count;
    bus.overflow = overflow_q;
  end

endmodule
